// File: rtl/icache_ctrl.sv
// Instruction-cache sequencing controller: tag/valid ownership, hit service and 8-beat line refill.
// Optional `ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_ctrl #(
  parameter int unsigned TAG_W = 20,
  parameter int unsigned BEATS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_addr,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_data,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        ram_wen,
  output logic [5:0]  ram_index,
  output logic [3:0]  ram_write_mask,
  output logic [5:0]  ram_r_offset,
  output logic [5:0]  ram_w_offset,
  output logic [63:0] ram_data_in,
  input  logic [31:0] ram_data_out
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned SETS  = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned OFF_W = 6;
  localparam int unsigned CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, COMPARE, REFILL_REQ, REFILL, RESP, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_mem [SETS];
  logic [CNT_W-1:0]   cnt_q;
  logic               flush_pend_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit_c;
  logic               last_beat_c;
  logic               addr_we, cnt_clr, cnt_inc, fill_done, flush_clr;

  assign idx         = addr_q[11:6];
  assign tag         = addr_q[31 -: TAG_W];
  assign hit_c       = valid_q[idx] & (tag_mem[idx] == tag);
  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

  // Array addressing always follows the latched fetch address
  assign ram_index      = idx;
  assign ram_r_offset   = addr_q[5:0];
  assign ram_w_offset   = OFF_W'({cnt_q, 3'b000});
  assign ram_data_in    = mem_resp_data;
  assign ram_write_mask = 4'd8;
  assign mem_req_addr   = {addr_q[31:6], 6'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    addr_we        = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    fill_done      = 1'b0;
    flush_clr      = 1'b0;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    mem_req_valid  = 1'b0;
    ram_wen        = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) begin
          state_d = FLUSH;
        end else begin
          cpu_req_ready = rst_n;
          if (cpu_req_valid) begin
            addr_we = 1'b1;
            state_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        if (hit_c) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = ram_data_out;
          state_d        = IDLE;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_clr = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_resp_valid) begin
          ram_wen = 1'b1;
          cnt_inc = 1'b1;
          if (last_beat_c) begin
            fill_done = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = ram_data_out;
        state_d        = IDLE;
      end
      FLUSH: begin
        flush_clr = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address latch, beat counter, valid bits and deferred-flush latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (addr_we) addr_q <= cpu_req_addr & ~32'h3;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (flush_clr)      valid_q      <= '0;
      else if (fill_done) valid_q[idx] <= 1'b1;
      if (flush_clr)
        flush_pend_q <= 1'b0;
      else if (flush && state_q != IDLE && state_q != FLUSH)
        flush_pend_q <= 1'b1;
    end
  end

  // Tags are only meaningful under a set valid bit, so no reset is needed
  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[idx] <= tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == COMPARE) begin
      if (hit_c && hit_count != '1)        hit_count  <= hit_count + 32'd1;
      else if (!hit_c && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Sequencing controller for the instruction-cache data array (64 sets × 64-byte lines, byte-addressed, combinational read / synchronous write). It owns the tag and valid arrays, accepts fetch requests from the front end, serves hits from the array, and on a miss refills the whole line from memory in eight 64-bit beats before responding. It sits between the IF stage and the memory bus, and drives every port of the data array.

## Interface
Parameters:
- TAG_W, 20, tag width; address split is tag [31:12], index [11:6], offset [5:0]
- BEATS, 8, refill beats per line (64 bits each)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  fetch request
- cpu_req_ready  out  1  controller can accept a request
- cpu_req_addr  in  32  fetch address; bits [1:0] ignored (treated as 0)
- cpu_resp_valid  out  1  one-cycle pulse, instruction valid
- cpu_resp_data  out  32  instruction
- flush  in  1  invalidate all lines (fence.i)
- mem_req_valid  out  1  line-refill request
- mem_req_ready  in  1  memory accepted request
- mem_req_addr  out  32  line-aligned address {tag, index, 6'b0}
- mem_resp_valid  in  1  refill beat valid
- mem_resp_data  in  64  refill beat, lowest address first
- ram_wen  out  1  data-array write enable
- ram_index  out  6  set index
- ram_write_mask  out  4  bytes to write; constant 8
- ram_r_offset  out  6  read byte offset
- ram_w_offset  out  6  write byte offset
- ram_data_in  out  64  write data
- ram_data_out  in  32  read data (array instantiated with O_WIDTH = 32)

## Operation
- States: IDLE, COMPARE, REFILL_REQ, REFILL, RESP, FLUSH.
- IDLE: cpu_req_ready = 1 unless flush pending/asserted. A flush (input or pending latch) has priority over a request, goes to FLUSH. On cpu_req_valid & ready, latch address, go to COMPARE.
- COMPARE: hit = valid[index] & tag[index] == latched tag. Hit: cpu_resp_valid = 1, data = ram_data_out, go to IDLE. Miss: go to REFILL_REQ.
- REFILL_REQ: mem_req_valid = 1, held with stable address until mem_req_ready; then go to REFILL, beat counter = 0.
- REFILL: each mem_resp_valid cycle writes: ram_wen = 1, ram_w_offset = counter×8, ram_data_in = mem_resp_data; counter increments. On beat BEATS−1, write tag[index], set valid[index], go to RESP.
- RESP: cpu_resp_valid = 1 with word read from the refilled line; go to IDLE.
- FLUSH: clear all 64 valid bits in one cycle, clear pending latch, go to IDLE.
- flush asserted outside IDLE: sets pending latch; an in-progress refill completes and responds first.
- ram_index and ram_r_offset always reflect the latched address; ram_wen is 0 outside REFILL.
- Reset mid-refill: state IDLE, valid bits cleared, outstanding memory beats are not consumed; the memory side must tolerate an abandoned burst.

## Timing
- Reset values: cpu_req_ready 0 during reset, 1 the first cycle after (IDLE); cpu_resp_valid 0, cpu_resp_data 0, mem_req_valid 0, mem_req_addr 0, ram_wen 0, all valid bits 0, counters 0.
- Hit latency: request accepted at edge N, cpu_resp_valid high in cycle N+1.
- Miss: mem_req_valid from cycle N+2; after handshake, 8 beats (any gaps allowed); cpu_resp_valid exactly one cycle after the edge that writes the last beat.
- Back-to-back hits: one request per two cycles (IDLE, COMPARE).
- cpu_resp_valid is never held more than one cycle; the front end must accept it.

## Configuration
- ICACHE_STATS_EN: when defined, adds outputs hit_count and miss_count (32 bits each, reset 0, saturating at 0xFFFFFFFF) incremented in COMPARE on hit/miss; flush does not clear them. When undefined, the ports and counters do not exist.

## Test plan
- Cold miss at 0x8000_0040 -> mem_req_addr 0x8000_0040, 8 beats written at offsets 0..56, cpu_resp_data = low word of beat 0, valid[1] set.
- Fetch 0x8000_004C after that refill -> no mem_req_valid, response one cycle after acceptance with bytes 12..15 of the line.
- Hold mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr stable throughout, cpu_req_ready 0.
- Flush pulse during beat 3 of a refill -> refill completes and responds, then FLUSH; next fetch to same line misses.
- Conflict: 0x8000_0040 then 0x8000_1040 (same index, new tag) -> second misses, refills, replaces tag; third fetch to 0x8000_0040 misses again.
- rst_n low during beat 5 -> all outputs at reset values asynchronously; fetch after release misses.
